// File: rtl/interval_scheduler_if.sv
// Request/grant bundle between the requesters and the shared interval counter.
// The master side is the set of requesters; the slave side is the scheduler.
interface interval_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16
);
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] len;
  logic [NUM_REQ-1:0]       grant;
  logic                     busy;
  logic [WIDTH-1:0]         count;
  logic [NUM_REQ-1:0]       done;

  modport master (output req, len, input grant, busy, count, done);
  modport slave  (input req, len, output grant, busy, count, done);
endinterface

// File: rtl/interval_scheduler.sv
// Round-robin sequencer for one saturating up-counter shared by NUM_REQ requesters.
// The owner's length is captured at grant, capped at MAX_AMOUNT, then counted out.
module interval_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int WIDTH      = 16,
  parameter int MAX_AMOUNT = 22
) (
  input logic                  clk,
  input logic                  reset,
  interval_scheduler_if.slave  bus
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [WIDTH-1:0] CAP = WIDTH'(MAX_AMOUNT);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t               r_state;
  logic [PTR_W-1:0]     r_ptr;
  logic [PTR_W-1:0]     r_owner;
  logic [WIDTH-1:0]     r_count;
  logic [WIDTH-1:0]     r_target;
  logic [NUM_REQ-1:0]   r_grant;
  logic [NUM_REQ-1:0]   r_done;

  logic                 w_pick_vld;
  logic [PTR_W-1:0]     w_pick_idx;
  logic [WIDTH-1:0]     w_pick_len;
  logic                 w_owner_req;

  function automatic logic [WIDTH-1:0] sat_len(input logic [WIDTH-1:0] l);
    return (l > CAP) ? CAP : l;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Scan starts just after the last owner so that owner ends up last in line.
  always_comb begin
    int idx;
    w_pick_vld = 1'b0;
    w_pick_idx = '0;
    idx        = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(r_ptr) + k) % NUM_REQ;
      if (!w_pick_vld && bus.req[idx]) begin
        w_pick_vld = 1'b1;
        w_pick_idx = PTR_W'(idx);
      end
    end
  end

  assign w_pick_len  = bus.len[int'(w_pick_idx)*WIDTH +: WIDTH];
  assign w_owner_req = bus.req[r_owner];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ptr   <= PTR_W'(NUM_REQ - 1);
      r_owner <= '0;
      r_count <= '0;
      r_grant <= '0;
      r_done  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= '0;
          if (w_pick_vld) begin
            r_owner <= w_pick_idx;
            r_grant <= onehot(w_pick_idx);
            r_count <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (!w_owner_req) begin
            r_grant <= '0;
            r_ptr   <= r_owner;
            r_state <= S_IDLE;
          end else if (r_count != r_target) begin
            r_count <= r_count + 1'b1;
          end else begin
            r_done  <= r_grant;
            r_grant <= '0;
            r_ptr   <= r_owner;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= '0;
          r_state <= S_IDLE;
        end
        default: begin
          r_grant <= '0;
          r_done  <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Target is pure data: only meaningful while RUN, loaded on every grant.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && w_pick_vld) begin
      r_target <= sat_len(w_pick_len);
    end
  end

  assign bus.grant = r_grant;
  assign bus.done  = r_done;
  assign bus.count = r_count;
  assign bus.busy  = (r_state != S_IDLE);
endmodule

// File: tb/tb_interval_scheduler.sv
// Directed bench for interval_scheduler: single-job vectors from a table plus
// hand-written round-robin, abort and mid-run reset sequences.
module tb_interval_scheduler;
  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 16;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  interval_scheduler_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

  interval_scheduler #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .MAX_AMOUNT(22)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [63:0] len;
    int          owner;
    int          target;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Expects the request already applied while idle; leaves the DUT idle after DONE.
  task automatic run_job(input string tag, input int owner, input int target);
    logic [3:0] oh;
    int         busy_cycles;
    oh = 4'(1 << owner);
    busy_cycles = 0;
    step();
    check({tag, "_grant"}, 32'(bus.grant), 32'(oh));
    check({tag, "_count0"}, 32'(bus.count), 0);
    check({tag, "_done_low"}, 32'(bus.done), 0);
    if (bus.busy) busy_cycles++;
    for (int c = 1; c <= target; c++) begin
      step();
      if (bus.busy) busy_cycles++;
      if (bus.count != 16'(c) || bus.grant != oh || bus.done != 4'b0)
        check({tag, "_run_count"}, 32'(bus.count), 32'(c));
    end
    step();
    if (bus.busy) busy_cycles++;
    check({tag, "_done"}, 32'(bus.done), 32'(oh));
    check({tag, "_grant_off"}, 32'(bus.grant), 0);
    check({tag, "_final_count"}, 32'(bus.count), 32'(target));
    bus.req = 4'b0;
    step();
    check({tag, "_done_pulse"}, 32'(bus.done), 0);
    check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(target + 2));
    check({tag, "_idle"}, 32'(bus.busy), 0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    bus.req  = '0;
    bus.len  = '0;

    // {req, len3..len0, owner, capped target}
    vecs[0] = '{4'b0001, {16'd0, 16'd0, 16'd0, 16'd5},        0, 5};
    vecs[1] = '{4'b0001, {16'd0, 16'd0, 16'd0, 16'd100},      0, 22};
    vecs[2] = '{4'b0010, {16'd0, 16'd0, 16'd0, 16'd0},        1, 0};
    vecs[3] = '{4'b0100, {16'd0, 16'd22, 16'd0, 16'd0},       2, 22};
    vecs[4] = '{4'b1000, {16'd23, 16'd0, 16'd0, 16'd0},       3, 22};
    vecs[5] = '{4'b0110, {16'd0, 16'd9, 16'd3, 16'd0},        1, 3};
    vecs[6] = '{4'b1000, {16'hFFFF, 16'd0, 16'd0, 16'd0},     3, 22};

    reset = 1'b1;
    step();
    step();
    check("reset_grant", 32'(bus.grant), 0);
    check("reset_done", 32'(bus.done), 0);
    check("reset_count", 32'(bus.count), 0);
    check("reset_busy", 32'(bus.busy), 0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      do_reset();
      bus.len = vecs[i].len;
      bus.req = vecs[i].req;
      run_job($sformatf("vec%0d", i), vecs[i].owner, vecs[i].target);
    end

    // Idle with no request: count holds its last value (22 from the last vector).
    step();
    check("idle_hold_count", 32'(bus.count), 22);
    check("idle_no_grant", 32'(bus.grant), 0);

    // All four requesting, length 2: five-cycle jobs served 0,1,2,3,0.
    do_reset();
    bus.len = {16'd2, 16'd2, 16'd2, 16'd2};
    bus.req = 4'b1111;
    step();
    for (int j = 0; j < 5; j++) begin
      check($sformatf("rr%0d_grant", j), 32'(bus.grant), 32'(1 << (j % 4)));
      step();
      step();
      step();
      check($sformatf("rr%0d_done", j), 32'(bus.done), 32'(1 << (j % 4)));
      check($sformatf("rr%0d_excl", j), 32'(bus.grant), 0);
      step();
      check($sformatf("rr%0d_gap", j), 32'(bus.grant | bus.done), 0);
      step();
    end
    bus.req = 4'b0;

    // Owner drops its request mid-run: silent abort, pending requester 3 next.
    do_reset();
    bus.len = {16'd4, 16'd10, 16'd0, 16'd0};
    bus.req = 4'b0100;
    step();
    check("abort_grant", 32'(bus.grant), 32'b0100);
    bus.req = 4'b1100;
    for (int c = 0; c < 4; c++) step();
    check("abort_count4", 32'(bus.count), 4);
    bus.req = 4'b1000;
    step();
    check("abort_grant_off", 32'(bus.grant), 0);
    check("abort_no_done", 32'(bus.done), 0);
    check("abort_idle", 32'(bus.busy), 0);
    step();
    check("abort_next_grant", 32'(bus.grant), 32'b1000);
    check("abort_next_count", 32'(bus.count), 0);
    bus.req = 4'b0;
    step();
    step();

    // Reset mid-run at count 7, then requester 0 wins over requester 3.
    do_reset();
    bus.len = {16'd3, 16'd0, 16'd0, 16'd20};
    bus.req = 4'b1000;
    step();
    check("rst_pre_grant", 32'(bus.grant), 32'b1000);
    bus.req = 4'b0;
    step();
    bus.req = 4'b0001;
    step();
    check("rst_run_grant", 32'(bus.grant), 32'b0001);
    for (int c = 0; c < 7; c++) step();
    check("rst_count7", 32'(bus.count), 7);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_count", 32'(bus.count), 0);
    check("rst_grant", 32'(bus.grant), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_busy", 32'(bus.busy), 0);
    bus.req = 4'b1001;
    step();
    check("rst_prio0", 32'(bus.grant), 32'b0001);
    bus.req = 4'b0;
    step();
    step();
    check("rst_abort_no_done", 32'(bus.done), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
